// File: rtl/invsqrt_pipe_out.sv
// Output stage of the inverse-sqrt pipeline: maps special values at push time and buffers beats in a DEPTH-entry FIFO.
// Optional macro INVSQRT_ERR_CNT_EN adds a saturating err_count output that counts popped error beats.
module invsqrt_pipe_out #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [30:0] in_y,
    input  logic        in_error,
    output logic        backprn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_error
`ifdef INVSQRT_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   res_mem [DEPTH];
    logic          err_mem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    logic          push;
    logic          pop;
    logic [31:0]   map_result;
    logic          map_error;

    // Both handshake outputs come straight from the count register.
    assign backprn   = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = in_valid & backprn;
    assign pop  = out_valid & out_ready;

    always_comb begin
        map_result = {1'b0, in_y};
        map_error  = 1'b0;
        if (in_error) begin
            map_result = 32'h7FC0_0000;
            map_error  = 1'b1;
        end else if (in_y[30:23] == 8'hFF) begin
            map_result = 32'h7F80_0000;
            map_error  = 1'b1;
        end else if (in_y[30:23] == 8'h00) begin
            map_result = 32'h0000_0000;
            map_error  = 1'b0;
        end
    end

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the count alone says what is live.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            res_mem[wr_ptr_q] <= map_result;
            err_mem[wr_ptr_q] <= map_error;
        end
    end

    assign out_result = out_valid ? res_mem[rd_ptr_q] : 32'h0;
    assign out_error  = out_valid ? err_mem[rd_ptr_q] : 1'b0;

`ifdef INVSQRT_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (pop && out_error && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_invsqrt_pipe_out.sv
// Randomised and directed bench for invsqrt_pipe_out against a queue-based reference model.
// The err_count checks are compiled only when INVSQRT_ERR_CNT_EN is defined.
module tb_invsqrt_pipe_out;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [30:0] in_y = '0;
    logic        in_error = 1'b0;
    logic        backprn;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_error;
`ifdef INVSQRT_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    invsqrt_pipe_out #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_y       (in_y),
        .in_error   (in_error),
        .backprn    (backprn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_error  (out_error)
`ifdef INVSQRT_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] model_q [$];   // {error, result}
    int          model_err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] expect_map(input logic [30:0] y, input logic e);
        if (e)                 return {1'b1, 32'h7FC0_0000};
        if (y[30:23] == 8'hFF) return {1'b1, 32'h7F80_0000};
        if (y[30:23] == 8'h00) return {1'b0, 32'h0000_0000};
        return {1'b0, 1'b0, y};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},   32'(out_valid), 32'(model_q.size() != 0));
        check({tag, ".backprn"}, 32'(backprn),   32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            check({tag, ".result"}, out_result,       model_q[0][31:0]);
            check({tag, ".error"},  32'(out_error),   32'(model_q[0][32]));
        end else begin
            check({tag, ".result0"}, out_result,     32'h0);
            check({tag, ".error0"},  32'(out_error), 32'h0);
        end
`ifdef INVSQRT_ERR_CNT_EN
        check({tag, ".errcnt"}, 32'(err_count), 32'(model_err_cnt));
`endif
    endtask

    // One clock: drive at negedge, let the model decide what the edge does, check at the next negedge.
    task automatic cycle(input string tag, input logic v, input logic [30:0] y,
                         input logic e, input logic rdy, output logic accepted);
        logic do_push, do_pop;
        in_valid  = v;
        in_y      = y;
        in_error  = e;
        out_ready = rdy;
        do_push   = rstn && v && (model_q.size() != DEPTH);
        do_pop    = rstn && rdy && (model_q.size() != 0);
        accepted  = do_push;
        @(posedge clk);
        if (!rstn) begin
            model_q.delete();
            model_err_cnt = 0;
        end else begin
            if (do_pop) begin
                if (model_q[0][32] && model_err_cnt != 65535) model_err_cnt++;
                void'(model_q.pop_front());
            end
            if (do_push) model_q.push_back(expect_map(y, e));
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [30:0] rand_y();
        logic [30:0] y;
        y = 31'($urandom);
        case ($urandom_range(0, 5))
            0: y[30:23] = 8'hFF;
            1: y[30:23] = 8'h00;
            default: ;
        endcase
        return y;
    endfunction

    logic        acc;
    logic [30:0] beats [5];
    int          idx;
    int          budget;

    initial begin
        @(negedge clk);
        cycle("reset", 1'b1, 31'h3F00_0000, 1'b0, 1'b1, acc);
        cycle("reset", 1'b0, '0, 1'b0, 1'b0, acc);
        rstn = 1'b1;
        cycle("idle", 1'b0, '0, 1'b0, 1'b0, acc);

        // single beat, visible one cycle after the push
        cycle("single", 1'b1, 31'h3F00_0000, 1'b0, 1'b1, acc);
        check("single.out", out_result, 32'h3F00_0000);
        cycle("single_drain", 1'b0, '0, 1'b0, 1'b1, acc);

        // fill to full with ready low, then drain in order
        for (int i = 0; i < 5; i++) beats[i] = 31'h3E80_0000 + 31'(i * 'h1111);
        idx = 0;
        budget = 0;
        while ((idx < 5 || model_q.size() != 0) && budget < 50) begin
            cycle("fill", idx < 5, (idx < 5) ? beats[idx] : '0, 1'b0, budget >= 6, acc);
            if (acc) idx++;
            if (budget == 4) check("fill.held_count", 32'(idx), 32'd4);
            budget++;
        end
        check("fill.timeout", 32'(budget < 50), 32'd1);

        // special values
        cycle("sp_err", 1'b1, 31'h3F00_0000, 1'b1, 1'b0, acc);
        cycle("sp_inf", 1'b1, 31'h7F80_0001, 1'b0, 1'b0, acc);
        cycle("sp_ftz", 1'b1, 31'h0001_2345, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) cycle("sp_drain", 1'b0, '0, 1'b0, 1'b1, acc);

        // steady streaming: one push and one pop every cycle
        for (int i = 0; i < 100; i++) begin
            cycle("stream", 1'b1, rand_y(), 1'b0, 1'b1, acc);
            if (i > 0) check("stream.depth", 32'(model_q.size()), 32'd1);
        end
        cycle("stream_end", 1'b0, '0, 1'b0, 1'b1, acc);

        // reset with three buffered beats
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, rand_y(), 1'b0, 1'b0, acc);
        rstn = 1'b0;
        cycle("mid_rst", 1'b1, rand_y(), 1'b0, 1'b1, acc);
        rstn = 1'b1;
        check("mid_rst.valid", 32'(out_valid), 32'd0);
        check("mid_rst.backprn", 32'(backprn), 32'd1);
        for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0, '0, 1'b0, 1'b1, acc);

`ifdef INVSQRT_ERR_CNT_EN
        for (int i = 0; i < 3; i++) cycle("ec_push", 1'b1, rand_y(), 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) cycle("ec_pop", 1'b0, '0, 1'b0, 1'b1, acc);
        check("ec.three", 32'(err_count), 32'd3);
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.err_cnt_q;
        model_err_cnt = 65535;
        cycle("ec_sat_push", 1'b1, '0, 1'b1, 1'b0, acc);
        cycle("ec_sat_pop", 1'b0, '0, 1'b0, 1'b1, acc);
        check("ec.sat", 32'(err_count), 32'hFFFF);
`endif

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) rstn = 1'b0;
            cycle("rand", 1'($urandom), rand_y(), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) != 0), acc);
            rstn = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
